// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns byte-addressed MIPS loads/stores into
// word accesses on DataMemory, with read-modify-write for sub-word stores.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; misaligned requests pulse alignErr here
// RD_REQ  | enReadMem asserted, DataMemory captures the word this edge
// RD_DONE | ReadData valid; extract load lane or merge sub-word store
// WR      | enWriteMem asserted with the final word
module mem_access_unit #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              reqValid,
  input  logic [2:0]        memOp,
  input  logic [31:0]       byteAddr,
  input  logic [31:0]       storeData,
  output logic              ready,
  output logic [31:0]       loadData,
  output logic              loadValid,
  output logic              storeDone,
  output logic              alignErr,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       WriteData,
  output logic              enReadMem,
  output logic              enWriteMem,
  input  logic [31:0]       ReadData
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_DONE, WR} stateT;

  stateT              state;
  logic [2:0]         opReg;
  logic [ADDR_W+1:0]  addrReg;
  logic [15:0]        dataReg;

  logic               reqMisaligned;
  logic               opIsLoad;
  logic [1:0]         laneIdx;
  logic               hiHalf;
  logic [7:0]         rdByte;
  logic [15:0]        rdHalf;
  logic [31:0]        loadWord;
  logic [31:0]        mergedWord;
  logic               unusedAddrBits;

  // Upper address bits alias; they are deliberately dropped.
  assign unusedAddrBits = ^byteAddr[31:ADDR_W+2];

  assign ready      = (state == IDLE);
  assign enReadMem  = (state == RD_REQ);
  assign enWriteMem = (state == WR);
  assign Address    = addrReg[ADDR_W+1:2];
  assign opIsLoad   = (opReg <= OP_LBU);

  always_comb begin
    reqMisaligned = 1'b0;
    case (memOp)
      OP_LW, OP_SW:          reqMisaligned = (byteAddr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  reqMisaligned = byteAddr[0];
      default:               reqMisaligned = 1'b0;
    endcase
  end

  // Lane selection from the latched offset; big-endian mirrors the byte index.
  always_comb begin
    laneIdx = BIG_ENDIAN ? ~addrReg[1:0] : addrReg[1:0];
    hiHalf  = BIG_ENDIAN ? ~addrReg[1] : addrReg[1];
    rdHalf  = hiHalf ? ReadData[31:16] : ReadData[15:0];
    rdByte  = ReadData[7:0];
    mergedWord = ReadData;
    case (laneIdx)
      2'd0: begin rdByte = ReadData[7:0];   mergedWord[7:0]   = dataReg[7:0]; end
      2'd1: begin rdByte = ReadData[15:8];  mergedWord[15:8]  = dataReg[7:0]; end
      2'd2: begin rdByte = ReadData[23:16]; mergedWord[23:16] = dataReg[7:0]; end
      default: begin rdByte = ReadData[31:24]; mergedWord[31:24] = dataReg[7:0]; end
    endcase
    if (opReg == OP_SH) begin
      mergedWord = hiHalf ? {dataReg, ReadData[15:0]} : {ReadData[31:16], dataReg};
    end
  end

  always_comb begin
    loadWord = ReadData;
    case (opReg)
      OP_LH:   loadWord = {{16{rdHalf[15]}}, rdHalf};
      OP_LHU:  loadWord = {16'h0000, rdHalf};
      OP_LB:   loadWord = {{24{rdByte[7]}}, rdByte};
      OP_LBU:  loadWord = {24'h000000, rdByte};
      default: loadWord = ReadData;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      opReg     <= OP_LW;
      addrReg   <= '0;
      dataReg   <= '0;
      WriteData <= '0;
      loadData  <= '0;
      loadValid <= 1'b0;
      storeDone <= 1'b0;
      alignErr  <= 1'b0;
    end else begin
      loadValid <= 1'b0;
      storeDone <= 1'b0;
      alignErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            opReg   <= memOp;
            addrReg <= byteAddr[ADDR_W+1:0];
            dataReg <= storeData[15:0];
            if (reqMisaligned) begin
              alignErr <= 1'b1;
            end else if (memOp == OP_SW) begin
              WriteData <= storeData;
              state     <= WR;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        RD_REQ: state <= RD_DONE;
        RD_DONE: begin
          if (opIsLoad) begin
            loadData  <= loadWord;
            loadValid <= 1'b1;
            state     <= IDLE;
          end else begin
            WriteData <= mergedWord;
            state     <= WR;
          end
        end
        WR: begin
          storeDone <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 256-word DataMemory.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clock = 1'b0;
  logic        nReset;
  logic        reqValid;
  logic [2:0]  memOp;
  logic [31:0] byteAddr;
  logic [31:0] storeData;
  logic        ready;
  logic [31:0] loadData;
  logic        loadValid;
  logic        storeDone;
  logic        alignErr;
  logic [7:0]  Address;
  logic [31:0] WriteData;
  logic        enReadMem;
  logic        enWriteMem;
  logic [31:0] ReadData;

  logic [31:0] mem [256] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int kind; logic [31:0] data; int cyc;} evT;
  typedef struct {logic [7:0] addr; logic [31:0] data; int cyc;} wrT;
  evT evQ[$];
  wrT wrQ[$];

  mem_access_unit #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut (
    .clock(clock), .nReset(nReset), .reqValid(reqValid), .memOp(memOp),
    .byteAddr(byteAddr), .storeData(storeData), .ready(ready),
    .loadData(loadData), .loadValid(loadValid), .storeDone(storeDone),
    .alignErr(alignErr), .Address(Address), .WriteData(WriteData),
    .enReadMem(enReadMem), .enWriteMem(enWriteMem), .ReadData(ReadData)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (enWriteMem) mem[Address] <= WriteData;
    if (enReadMem)  ReadData <= mem[Address];
  end

  // Monitor: pops expected pulses and writes whenever the DUT presents them.
  always @(negedge clock) begin
    if (nReset) begin
      if (loadValid || storeDone || alignErr) begin
        evT e;
        int kind;
        kind = loadValid ? 0 : (storeDone ? 1 : 2);
        checks++;
        if ((32'(loadValid) + 32'(storeDone) + 32'(alignErr)) > 1) begin
          errors++;
          $display("FAIL pulse_overlap: got lv=%0b sd=%0b ae=%0b, required one pulse", loadValid, storeDone, alignErr);
        end else if (evQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
          e = evQ.pop_front();
          if (e.kind != kind || e.cyc != cyc || (kind == 0 && loadData != e.data)) begin
            errors++;
            $display("FAIL pulse: got kind %0d data %h cycle %0d, required kind %0d data %h cycle %0d",
                     kind, loadData, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
      if (enWriteMem) begin
        wrT w;
        checks++;
        if (wrQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", Address, WriteData);
        end else begin
          w = wrQ.pop_front();
          if (w.addr != Address || w.data != WriteData || w.cyc != cyc) begin
            errors++;
            $display("FAIL write: got addr %h data %h cycle %0d, required addr %h data %h cycle %0d",
                     Address, WriteData, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
    end
  end

  task automatic checkResetVals(input string name);
    logic [77:0] got;
    got = {ready, loadData, loadValid, storeDone, alignErr, Address, WriteData, enReadMem, enWriteMem};
    checks++;
    if (got !== {1'b1, 32'h0, 3'b000, 8'h00, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, {1'b1, 32'h0, 3'b000, 8'h00, 32'h0, 2'b00});
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int acc);
    @(negedge clock);
    memOp = op; byteAddr = a; storeData = d; reqValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ready) break;
      @(negedge clock);
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=0, required ready=1 within 20 cycles");
    end
    @(posedge clock);
    #1;
    acc = cyc;
    if (!hold) reqValid = 1'b0;
  endtask

  task automatic pushLoad(input int acc, input logic [31:0] expd);
    evQ.push_back('{0, expd, acc + 2});
  endtask

  task automatic doLoad(input logic [2:0] op, input logic [31:0] a, input logic [31:0] expd);
    int acc;
    issue(op, a, 32'h0, 1'b0, acc);
    pushLoad(acc, expd);
    drain();
  endtask

  task automatic doSW(input logic [31:0] a, input logic [31:0] d);
    int acc;
    issue(SW, a, d, 1'b0, acc);
    wrQ.push_back('{a[9:2], d, acc});
    evQ.push_back('{1, 32'h0, acc + 1});
    drain();
  endtask

  task automatic doSub(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] expWord);
    int acc;
    issue(op, a, d, 1'b0, acc);
    wrQ.push_back('{a[9:2], expWord, acc + 2});
    evQ.push_back('{1, 32'h0, acc + 3});
    drain();
  endtask

  task automatic doBad(input logic [2:0] op, input logic [31:0] a);
    int acc;
    issue(op, a, 32'hDEADBEEF, 1'b0, acc);
    evQ.push_back('{2, 32'h0, acc});
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (!ready || enReadMem || enWriteMem) begin
        errors++;
        $display("FAIL align_quiet: got ready=%0b rd=%0b wr=%0b, required 1 0 0", ready, enReadMem, enWriteMem);
      end
    end
    drain();
  endtask

  task automatic drain();
    int i;
    reqValid = 1'b0;
    for (i = 0; i < 60; i++) begin
      @(negedge clock);
      if (evQ.size() == 0 && wrQ.size() == 0 && ready) break;
    end
    if (i == 60) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d events %0d writes pending, required 0", evQ.size(), wrQ.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc1, acc2;
    nReset = 1'b0; reqValid = 1'b0; memOp = LW; byteAddr = 32'h0; storeData = 32'h0;
    repeat (3) @(negedge clock);
    checkResetVals("reset_state");
    nReset = 1'b1;
    @(negedge clock);
    checkResetVals("idle_after_reset");

    doSW(32'h10, 32'hF0FFFFFF);
    doLoad(LW, 32'h10, 32'hF0FFFFFF);

    doSub(SB, 32'h11, 32'h000000AB, 32'hF0FFABFF);
    doLoad(LB, 32'h11, 32'hFFFFFFAB);
    doLoad(LBU, 32'h11, 32'h000000AB);

    doSub(SH, 32'h12, 32'h00001234, 32'h1234ABFF);
    doLoad(LH, 32'h12, 32'h00001234);
    doLoad(LHU, 32'h10, 32'h0000ABFF);
    doLoad(LH, 32'h10, 32'hFFFFABFF);
    doLoad(LB, 32'h13, 32'h00000012);
    doLoad(LB, 32'h10, 32'hFFFFFFFF);

    doBad(LW, 32'h13);
    doBad(SH, 32'h11);
    doBad(SW, 32'h02);

    // SB aborted by reset while in RD_DONE
    issue(SB, 32'h11, 32'h00000055, 1'b0, acc1);
    @(negedge clock);
    @(negedge clock);
    nReset = 1'b0;
    #1;
    checkResetVals("reset_mid_op");
    @(negedge clock);
    checkResetVals("reset_mid_op_held");
    nReset = 1'b1;
    repeat (4) @(negedge clock);
    doLoad(LW, 32'h10, 32'h1234ABFF);

    // Back-to-back: SW held while the LW is in flight
    issue(LW, 32'h10, 32'h0, 1'b1, acc1);
    pushLoad(acc1, 32'h1234ABFF);
    issue(SW, 32'h20, 32'hCAFEBABE, 1'b0, acc2);
    wrQ.push_back('{8'h08, 32'hCAFEBABE, acc2});
    evQ.push_back('{1, 32'h0, acc2 + 1});
    checks++;
    if (acc2 != acc1 + 3) begin
      errors++;
      $display("FAIL b2b_accept: got accept at +%0d, required +3", acc2 - acc1);
    end
    drain();
    doLoad(LW, 32'h20, 32'hCAFEBABE);
    doLoad(LW, 32'h410, 32'h1234ABFF);

    repeat (4) @(negedge clock);
    checks++;
    if (evQ.size() != 0 || wrQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d events %0d writes, required 0", evQ.size(), wrQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
